// File: rtl/bitwise_logic_unit.sv
// bitwise_logic_unit
// Registered AND/OR/XOR/pass-A unit with valid/ready handshakes on both
// sides. A beat can either produce a result on its own or open a group
// whose beats are folded together with the group's op before the single
// folded result is presented downstream.
module bitwise_logic_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_A,
    input  logic [WIDTH-1:0] data_B,
    input  logic [1:0]       op,
    input  logic             accum,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] beat_count,
    output logic             count_sat,
    output logic             result_zero
);

    // Operation encodings
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;

    // Group state: IDLE means no group is open, ACCUM means a group is open
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Group accumulator state
    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [1:0]       r_grpOp;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;

    // Output register bank
    logic             r_outValid;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_beatCount;
    logic             r_countSat;
    logic             r_resultZero;

    // Handshake and datapath wires
    logic             w_accept;
    logic             w_consume;
    logic [1:0]       w_opEff;
    logic [WIDTH-1:0] w_beat;
    logic [WIDTH-1:0] w_fold;
    logic             w_cntBlocked;
    logic [CNT_W-1:0] w_cntInc;
    logic             w_satInc;

    // Next-state wires
    logic [0:0]       w_stateNext;
    logic [WIDTH-1:0] w_accNext;
    logic [1:0]       w_grpOpNext;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_satNext;
    logic             w_load;
    logic [WIDTH-1:0] w_loadResult;
    logic [CNT_W-1:0] w_loadCount;
    logic             w_loadSat;
    logic             w_outValidNext;

    // Per-beat bitwise operation; pass-A forwards operand A untouched
    function automatic logic [WIDTH-1:0] applyOp(input logic [1:0]       sel,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] v;
        case (sel)
            OP_AND:  v = a & b;
            OP_OR:   v = a | b;
            OP_XOR:  v = a ^ b;
            default: v = a;
        endcase
        return v;
    endfunction

    // Folding of a new beat into the accumulator; pass-A keeps the latest beat
    function automatic logic [WIDTH-1:0] foldOp(input logic [1:0]       sel,
                                                input logic [WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0] beat);
        logic [WIDTH-1:0] v;
        case (sel)
            OP_AND:  v = acc & beat;
            OP_OR:   v = acc | beat;
            OP_XOR:  v = acc ^ beat;
            default: v = beat;
        endcase
        return v;
    endfunction

    // Upstream may push whenever the output slot is empty or being drained
    assign in_ready  = !r_outValid | out_ready;
    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_outValid & out_ready;

    // Once a group is open its op is frozen; later op inputs are ignored
    assign w_opEff = (r_state == S_ACCUM) ? r_grpOp : op;
    assign w_beat  = applyOp(w_opEff, data_A, data_B);
    assign w_fold  = foldOp(r_grpOp, r_acc, w_beat);

    // Beat counter saturates instead of wrapping and remembers that it did
    assign w_cntBlocked = (r_cnt == CNT_MAX);
    assign w_cntInc     = w_cntBlocked ? r_cnt : r_cnt + CNT_ONE;
    assign w_satInc     = r_sat | w_cntBlocked;

    // Group sequencing and output-load decision for the accepted beat
    always_comb begin
        w_stateNext  = r_state;
        w_accNext    = r_acc;
        w_grpOpNext  = r_grpOp;
        w_cntNext    = r_cnt;
        w_satNext    = r_sat;
        w_load       = 1'b0;
        w_loadResult = '0;
        w_loadCount  = '0;
        w_loadSat    = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (!accum || in_last) begin
                        w_load       = 1'b1;
                        w_loadResult = w_beat;
                        w_loadCount  = CNT_ONE;
                        w_loadSat    = 1'b0;
                    end else begin
                        w_accNext   = w_beat;
                        w_grpOpNext = op;
                        w_cntNext   = CNT_ONE;
                        w_satNext   = 1'b0;
                        w_stateNext = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (!in_last) begin
                        w_accNext = w_fold;
                        w_cntNext = w_cntInc;
                        w_satNext = w_satInc;
                    end else begin
                        w_load       = 1'b1;
                        w_loadResult = w_fold;
                        w_loadCount  = w_cntInc;
                        w_loadSat    = w_satInc;
                        w_stateNext  = S_IDLE;
                    end
                end
                default: begin
                    w_stateNext = S_IDLE;
                end
            endcase
        end
    end

    // A new result wins over a consume so back-to-back results leave no bubble
    always_comb begin
        w_outValidNext = r_outValid;
        if (w_load) begin
            w_outValidNext = 1'b1;
        end else if (w_consume) begin
            w_outValidNext = 1'b0;
        end
    end

    // Group accumulator registers; reset drops any partially built group
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_grpOp <= OP_AND;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_acc   <= w_accNext;
            r_grpOp <= w_grpOpNext;
            r_cnt   <= w_cntNext;
            r_sat   <= w_satNext;
        end
    end

    // Output registers only change on a load, so they hold under backpressure
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_outValid   <= 1'b0;
            r_result     <= '0;
            r_beatCount  <= '0;
            r_countSat   <= 1'b0;
            r_resultZero <= 1'b0;
        end else begin
            r_outValid <= w_outValidNext;
            if (w_load) begin
                r_result     <= w_loadResult;
                r_beatCount  <= w_loadCount;
                r_countSat   <= w_loadSat;
                r_resultZero <= (w_loadResult == '0);
            end
        end
    end

    assign out_valid   = r_outValid;
    assign result      = r_result;
    assign beat_count  = r_beatCount;
    assign count_sat   = r_countSat;
    assign result_zero = r_resultZero;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// tb_bitwise_logic_unit
// Table of beats with expected folded results fed through a scoreboard,
// plus hand-written backpressure and reset-mid-group sequences.
module tb_bitwise_logic_unit;

    localparam int W  = 32;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  data_A;
    logic [W-1:0]  data_B;
    logic [1:0]    op;
    logic          accum;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [CW-1:0] beat_count;
    logic          count_sat;
    logic          result_zero;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [1:0]    op;
        logic          accum;
        logic          last;
        logic          hasOut;
        logic [W-1:0]  expResult;
        logic [CW-1:0] expCount;
        logic          expSat;
    } vec_t;

    typedef struct {
        logic [W-1:0]  result;
        logic [CW-1:0] count;
        logic          sat;
        logic          zero;
    } exp_t;

    exp_t sbQueue[$];
    vec_t vecs[24];

    bitwise_logic_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_A      (data_A),
        .data_B      (data_B),
        .op          (op),
        .accum       (accum),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .beat_count  (beat_count),
        .count_sat   (count_sat),
        .result_zero (result_zero)
    );

    // Free-running clock
    always #5 clock = ~clock;

    function automatic vec_t mkVec(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] o, input logic ac, input logic la,
                                   input logic ho, input logic [W-1:0] er,
                                   input logic [CW-1:0] ec, input logic es);
        vec_t v;
        v.a = a; v.b = b; v.op = o; v.accum = ac; v.last = la;
        v.hasOut = ho; v.expResult = er; v.expCount = ec; v.expSat = es;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one beat, waits (bounded) for acceptance and records the expected output
    task automatic applyStimulus(input vec_t v);
        bit accepted;
        data_A   = v.a;
        data_B   = v.b;
        op       = v.op;
        accum    = v.accum;
        in_last  = v.last;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL accept_timeout: in_ready stuck at 0, expected 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        if (v.hasOut) begin
            exp_t e;
            e.result = v.expResult;
            e.count  = v.expCount;
            e.sat    = v.expSat;
            e.zero   = (v.expResult == '0);
            sbQueue.push_back(e);
        end
    endtask

    // Scoreboard: every consumed result is matched against the oldest expectation
    always @(negedge clock) begin
        exp_t e;
        if (resetn && out_valid && out_ready) begin
            if (sbQueue.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_output: result 0x%08h with no expected entry", result);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("result", result, e.result);
                checkOutput("beat_count", 32'(beat_count), 32'(e.count));
                checkOutput("count_sat", 32'(count_sat), 32'(e.sat));
                checkOutput("result_zero", 32'(result_zero), 32'(e.zero));
            end
        end
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        // Singles
        vecs[0]  = mkVec(32'hF0F0_0000, 32'h0000_0F0F, 2'b01, 1'b0, 1'b0, 1'b1, 32'hF0F0_0F0F, 2'd1, 1'b0);
        vecs[1]  = mkVec(32'hFF00_FF00, 32'h0F0F_0F0F, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0F00_0F00, 2'd1, 1'b0);
        vecs[2]  = mkVec(32'h1234_5678, 32'h1234_5678, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 2'd1, 1'b0);
        vecs[3]  = mkVec(32'hDEAD_BEEF, 32'h1234_5678, 2'b11, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'd1, 1'b0);
        // XOR fold, 3 beats
        vecs[4]  = mkVec(32'h0000_00FF, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        vecs[5]  = mkVec(32'h0000_0F0F, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        vecs[6]  = mkVec(32'h0000_00F0, 32'h0, 2'b10, 1'b1, 1'b1, 1'b1, 32'h0000_0F00, 2'd3, 1'b0);
        // AND group, op driven OR on second beat is ignored
        vecs[7]  = mkVec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        vecs[8]  = mkVec(32'h0000_FFFF, 32'hFFFF_FFFF, 2'b01, 1'b0, 1'b1, 1'b1, 32'h0000_FFFF, 2'd2, 1'b0);
        // Pass-A group keeps the latest beat
        vecs[9]  = mkVec(32'h1111_1111, 32'hAAAA_AAAA, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        vecs[10] = mkVec(32'h2222_2222, 32'h5555_5555, 2'b00, 1'b1, 1'b1, 1'b1, 32'h2222_2222, 2'd2, 1'b0);
        // OR group, accum dropped mid-group is ignored
        vecs[11] = mkVec(32'h0000_0001, 32'h0000_0002, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        vecs[12] = mkVec(32'h0000_0004, 32'h0000_0000, 2'b10, 1'b0, 1'b1, 1'b1, 32'h0000_0007, 2'd2, 1'b0);
        // accum with in_last on the first beat is a single
        vecs[13] = mkVec(32'h0000_0000, 32'hFFFF_FFFF, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 2'd1, 1'b0);
        // Saturating 5-beat OR group, then a single
        vecs[14] = mkVec(32'h0000_0001, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        vecs[15] = mkVec(32'h0000_0002, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        vecs[16] = mkVec(32'h0000_0004, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        vecs[17] = mkVec(32'h0000_0008, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        vecs[18] = mkVec(32'h0000_0010, 32'h0, 2'b01, 1'b1, 1'b1, 1'b1, 32'h0000_001F, 2'd3, 1'b1);
        vecs[19] = mkVec(32'h0000_0005, 32'h0000_0003, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0000_0006, 2'd1, 1'b0);
        // 4-beat OR group saturates on its final beat
        vecs[20] = mkVec(32'h0000_0100, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        vecs[21] = mkVec(32'h0000_0200, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        vecs[22] = mkVec(32'h0000_0400, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        vecs[23] = mkVec(32'h0000_0800, 32'h0, 2'b01, 1'b1, 1'b1, 1'b1, 32'h0000_0F00, 2'd3, 1'b1);

        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_A    = '0;
        data_B    = '0;
        op        = 2'b00;
        accum     = 1'b0;
        in_last   = 1'b0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_beat_count", 32'(beat_count), 32'd0);
        checkOutput("rst_count_sat", 32'(count_sat), 32'd0);
        checkOutput("rst_result_zero", 32'(result_zero), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        $display("[TB] table-driven vectors");
        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i]);
        end
        repeat (3) @(posedge clock);
        #1;

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(mkVec(32'hAAAA_5555, 32'hFFFF_0000, 2'b00, 1'b0, 1'b0, 1'b1, 32'hAAAA_0000, 2'd1, 1'b0));
        repeat (5) begin
            @(negedge clock);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_result", result, 32'hAAAA_0000);
            checkOutput("bp_beat_count", 32'(beat_count), 32'd1);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        applyStimulus(mkVec(32'h0F0F_0F0F, 32'hFFFF_FFFF, 2'b10, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0, 2'd1, 1'b0));
        @(negedge clock);
        checkOutput("bp_reload_valid", 32'(out_valid), 32'd1);
        repeat (3) @(posedge clock);
        #1;

        $display("[TB] reset mid-group");
        applyStimulus(mkVec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0));
        applyStimulus(mkVec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0));
        resetn = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        @(negedge clock);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_result", result, 32'd0);
        checkOutput("mid_rst_beat_count", 32'(beat_count), 32'd0);
        checkOutput("mid_rst_count_sat", 32'(count_sat), 32'd0);
        checkOutput("mid_rst_result_zero", 32'(result_zero), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        applyStimulus(mkVec(32'h0, 32'h0, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0, 2'd1, 1'b0));
        repeat (3) @(posedge clock);
        #1;

        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

Parametrised, registered bitwise logic unit for the SimpleALU datapath. It computes AND/OR/XOR/pass-A of two WIDTH-bit operands per beat. It can also fold a multi-beat group of results into one output, for mask building and reduction. Input and output use valid/ready handshakes, with one output register and a group accumulator.

## Interface
Parameters:
- WIDTH, 32, operand/result width (≥1)
- CNT_W, 8, width of beat counter (≥1)

Ports:
- clock  input  1  single clock; all state updates on rising edge
- resetn  input  1  reset; synchronous, active-low
- in_valid  input  1  input beat valid
- in_ready  output  1  unit can accept a beat this cycle
- data_A  input  WIDTH  operand A
- data_B  input  WIDTH  operand B
- op  input  2  00 AND, 01 OR, 10 XOR, 11 pass-A
- accum  input  1  1 = beat opens a multi-beat group (sampled only on first beat)
- in_last  input  1  final beat of group
- out_valid  output  1  result registers hold an unconsumed result
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  (folded) logic result
- beat_count  output  CNT_W  beats in the group, saturating
- count_sat  output  1  beat_count saturated during this group
- result_zero  output  1  result == 0

## Operation
- Handshakes:
  - accept = in_valid & in_ready.
  - in_ready = !out_valid | out_ready. This applies uniformly, including for non-last group beats.
  - A result is consumed when out_valid & out_ready.
- Per-beat value r = data_A op_eff data_B. The effective op (op_eff) is defined below; pass-A gives r = data_A.
- State IDLE (no open group):
  - On accept, op_eff = op.
  - If accum=0 or in_last=1: load the output with result=r, beat_count=1, count_sat=0, and set out_valid. Stay in IDLE.
  - Otherwise: acc=r, grp_op=op, cnt=1, sat=0, and go to ACCUM.
- State ACCUM (group open):
  - On accept, op_eff = grp_op. The op and accum inputs are ignored.
  - The folded value is new = acc grp_op r, where AND→acc&r, OR→acc|r, XOR→acc^r, and pass-A→r (the latest beat wins).
  - cnt increments, saturating at 2^CNT_W−1; sat is set when an increment is blocked.
  - If in_last=0: acc=new, stay in ACCUM.
  - If in_last=1: load the output with result=new, beat_count=cnt+1 (saturated), count_sat=sat', set out_valid, and return to IDLE.
- result_zero is registered together with result.
- out_valid clears on consume unless a new result loads in the same cycle; a load takes priority and out_valid stays 1.
- Output registers hold stable while out_valid & !out_ready.
- Beat count wrap: it never wraps. beat_count stays at max, count_sat=1.

## Timing
- Reset (resetn=0 at a clock edge):
  - out_valid=0, result=0, beat_count=0, count_sat=0, result_zero=0, state=IDLE, acc=0, cnt=0.
  - in_ready reads 1 after the reset cycle, since out_valid=0.
- Reset mid-group discards the partial group. The next accepted beat starts a new group.
- Latency: result is valid in the cycle after the accepting edge of a single beat or last beat.
- Throughput: 1 beat/cycle when out_ready is held 1. Back-to-back single beats give out_valid continuously high.
- Simultaneous consume and load: the new result replaces the old at the same edge, with no bubble.
- in_ready depends combinationally on out_ready (no skid buffer). in_valid must not depend combinationally on in_ready.

## Test plan
- **Single beat, OR:** accum=0, op=01, A=0xF0F0_0000, B=0x0000_0F0F → one cycle later result=0xF0F0_0F0F, beat_count=1, result_zero=0, out_valid=1.
- **XOR fold, 3 beats:**
  - Stimulus: accum=1, op=10, with (A,B) = (0x0000_00FF,0), (0x0000_0F0F,0), (0x0000_00F0,0), in_last on the third beat.
  - Required: result=0x0000_0F00, beat_count=3, out_valid asserted only after the third beat.
- **Op change ignored mid-group:** AND group with beats 0xFFFF_FFFF, then 0x0000_FFFF (op driven 01 on this beat), all with B=0xFFFF_FFFF → result=0x0000_FFFF.
- **Backpressure:**
  - Stimulus: hold out_ready=0 while a result is pending.
  - Required: in_ready=0, and result/beat_count stay stable for 5 cycles.
  - Then raise out_ready with a new beat presented: the old result is consumed and the new one is loaded at the same edge.
- **Saturation (CNT_W=2):** 5-beat OR group → beat_count=3, count_sat=1. The following single beat → beat_count=1, count_sat=0.
- **Reset mid-group:**
  - Stimulus: after 2 AND beats, assert resetn=0 for 1 cycle. Then send a single beat, OR, A=0, B=0.
  - Required: outputs are 0 after reset; then result=0, result_zero=1, beat_count=1 with no trace of the prior group.
